// File: rtl/alu_regfile_seq_pkg.sv
// Shared constants for the operand-fetch / write-back sequencer: widths, ALU opcodes, FSM states.
package alu_regfile_seq_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
  localparam logic [OP_W-1:0] OP_SLT  = 3'b110;
  localparam logic [OP_W-1:0] OP_SLL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_regfile_seq_if.sv
// Bundle of command, ALU-side and status signals for alu_regfile_seq (master = requester/ALU, slave = sequencer).
interface alu_regfile_seq_if
  import alu_regfile_seq_pkg::*;
#(
  parameter int DATA_W = alu_regfile_seq_pkg::DATA_W,
  parameter int ADDR_W = alu_regfile_seq_pkg::ADDR_W,
  parameter int OP_W   = alu_regfile_seq_pkg::OP_W
);
  // Handshake: a request is accepted on any rising edge where start=1 and busy=0;
  // start while busy is dropped, never queued; done pulses for exactly one cycle
  // in write-back, and the next request may be issued in the cycle that follows.
  logic              start;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [ADDR_W-1:0] rw_addr;
  logic [OP_W-1:0]   op_in;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_f;
  logic              alu_of;
  logic [DATA_W-1:0] result;
  logic              zf;
  logic              of;
  logic              busy;
  logic              done;
  state_t            state;

  modport master (
    output start, ra_addr, rb_addr, rw_addr, op_in,
    output ext_we, ext_addr, ext_wdata,
    output alu_f, alu_of,
    input  alu_a, alu_b, alu_op,
    input  result, zf, of, busy, done, state
  );

  modport slave (
    input  start, ra_addr, rb_addr, rw_addr, op_in,
    input  ext_we, ext_addr, ext_wdata,
    input  alu_f, alu_of,
    output alu_a, alu_b, alu_op,
    output result, zf, of, busy, done, state
  );

endinterface

// File: rtl/alu_regfile_seq_regfile_2r1w.sv
// Register array with two asynchronous read ports, one synchronous write port and synchronous clear.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_regfile_seq.sv
// Operand-fetch / write-back sequencer around an external ALU: IDLE -> READ -> EXEC -> WB.
// Optional build macro REG_ZERO_HARDWIRED_EN makes register 0 read as zero and discard writes.
module alu_regfile_seq
  import alu_regfile_seq_pkg::*;
#(
  parameter int DATA_W = alu_regfile_seq_pkg::DATA_W,
  parameter int ADDR_W = alu_regfile_seq_pkg::ADDR_W,
  parameter int OP_W   = alu_regfile_seq_pkg::OP_W
) (
  input logic             clk,
  input logic             rst,
  alu_regfile_seq_if.slave bus
);

  state_t state, state_nx;

  logic [ADDR_W-1:0] ra_q, rb_q, rw_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, result_q;
  logic [OP_W-1:0]   alu_op_q;
  logic              zf_q, of_q;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] raw_a, raw_b, rd_a, rd_b;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.start) state_nx = ST_READ;
      ST_READ: state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_WB;
      ST_WB:   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q     <= '0;
      rb_q     <= '0;
      rw_q     <= '0;
      op_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      zf_q     <= 1'b1;
      of_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            ra_q <= bus.ra_addr;
            rb_q <= bus.rb_addr;
            rw_q <= bus.rw_addr;
            op_q <= bus.op_in;
          end
        end
        ST_READ: begin
          alu_a_q  <= rd_a;
          alu_b_q  <= rd_b;
          alu_op_q <= op_q;
        end
        ST_EXEC: begin
          result_q <= bus.alu_f;
          zf_q     <= (bus.alu_f == '0);
          of_q     <= bus.alu_of;
        end
        default: ;
      endcase
    end
  end

  // Single write port: write-back owns it in WB, external loads may only use it in IDLE.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state == ST_WB) begin
      wr_en   = 1'b1;
      wr_addr = rw_q;
      wr_data = result_q;
    end else if (state == ST_IDLE && bus.ext_we) begin
      wr_en   = 1'b1;
      wr_addr = bus.ext_addr;
      wr_data = bus.ext_wdata;
    end
`ifdef REG_ZERO_HARDWIRED_EN
    if (wr_addr == '0) wr_en = 1'b0;
`endif
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a (ra_q),
    .raddr_b (rb_q),
    .rdata_a (raw_a),
    .rdata_b (raw_b)
  );

`ifdef REG_ZERO_HARDWIRED_EN
  assign rd_a = (ra_q == '0) ? '0 : raw_a;
  assign rd_b = (rb_q == '0) ? '0 : raw_b;
`else
  assign rd_a = raw_a;
  assign rd_b = raw_b;
`endif

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;
  assign bus.result = result_q;
  assign bus.zf     = zf_q;
  assign bus.of     = of_q;
  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_WB);
  assign bus.state  = state;

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Bench for alu_regfile_seq: behavioural ALU on the bus, array-based register model, expected queue.
module tb_alu_regfile_seq;
  import alu_regfile_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_regfile_seq_if bus ();

  alu_regfile_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU behaviour (bit 32 = overflow) ----------------
  function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] f;
    logic        v;
    v = 1'b0;
    case (op)
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_XOR:  f = a ^ b;
      OP_XNOR: f = ~(a ^ b);
      OP_ADD:  begin f = a + b; v = (a[31] == b[31]) && (f[31] != a[31]); end
      OP_SUB:  begin f = a - b; v = (a[31] != b[31]) && (f[31] != a[31]); end
      OP_SLT:  f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: f = a << b[4:0];
    endcase
    return {v, f};
  endfunction

  logic [32:0] alu_out;
  always_comb begin
    alu_out    = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
    bus.alu_f  = alu_out[31:0];
    bus.alu_of = alu_out[32];
  end

  // ---------------- reference register file ----------------
  logic [31:0] rf_m [32];
  logic [32:0] exp_q [$];

  function automatic logic [31:0] model_rd(input logic [4:0] a);
`ifdef REG_ZERO_HARDWIRED_EN
    if (a == 5'd0) return 32'd0;
`endif
    return rf_m[a];
  endfunction

  task automatic model_wr(input logic [4:0] a, input logic [31:0] d);
`ifdef REG_ZERO_HARDWIRED_EN
    if (a == 5'd0) return;
`endif
    rf_m[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    exp_q.delete();
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.ra_addr   = '0;
    bus.rb_addr   = '0;
    bus.rw_addr   = '0;
    bus.op_in     = '0;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = '0;
    bus.ext_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic ext_load(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.ext_we    = 1'b1;
    bus.ext_addr  = a;
    bus.ext_wdata = d;
    model_wr(a, d);
    @(negedge clk);
    bus.ext_we = 1'b0;
  endtask

  // Issues one request from IDLE and returns at the first negedge back in IDLE.
  task automatic run_op(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                        input logic [2:0] op, input bit with_ext,
                        input logic [4:0] ea, input logic [31:0] ed);
    logic [31:0] a, b;
    logic [32:0] e;
    int          lat;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.ra_addr = ra;
    bus.rb_addr = rb;
    bus.rw_addr = rw;
    bus.op_in   = op;
    if (with_ext) begin
      bus.ext_we    = 1'b1;
      bus.ext_addr  = ea;
      bus.ext_wdata = ed;
      model_wr(ea, ed);
    end
    a = model_rd(ra);
    b = model_rd(rb);
    exp_q.push_back(alu_ref(op, a, b));
    @(negedge clk);
    bus.start  = 1'b0;
    bus.ext_we = 1'b0;
    check("busy_run", {31'd0, bus.busy}, 32'd1);
    lat = 1;
    while (!bus.done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 32'd3);
    e = exp_q.pop_front();
    check("result", bus.result, e[31:0]);
    check("zf", {31'd0, bus.zf}, {31'd0, (e[31:0] == 32'd0)});
    check("of", {31'd0, bus.of}, {31'd0, e[32]});
    check("alu_a", bus.alu_a, a);
    check("alu_b", bus.alu_b, b);
    check("alu_op", {29'd0, bus.alu_op}, {29'd0, op});
    @(negedge clk);
    check("done_clr", {31'd0, bus.done}, 32'd0);
    check("busy_clr", {31'd0, bus.busy}, 32'd0);
    model_wr(rw, e[31:0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    model_clear();
    do_reset();

    // reset state
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_zf", {31'd0, bus.zf}, 32'd1);
    check("rst_of", {31'd0, bus.of}, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    run_op(5'd1, 5'd2, 5'd9, OP_ADD, 1'b0, 5'd0, 32'd0);
    check("t1_a", bus.alu_a, 32'd0);
    check("t1_b", bus.alu_b, 32'd0);

    // add, then read back R3
    ext_load(5'd1, 32'd5);
    ext_load(5'd2, 32'd7);
    run_op(5'd1, 5'd2, 5'd3, OP_ADD, 1'b0, 5'd0, 32'd0);
    check("t2_res", bus.result, 32'd12);
    check("t2_zf", {31'd0, bus.zf}, 32'd0);
    run_op(5'd3, 5'd3, 5'd8, OP_OR, 1'b0, 5'd0, 32'd0);
    check("t2_r3", bus.result, 32'd12);

    // subtract overflow
    ext_load(5'd1, 32'h8000_0000);
    ext_load(5'd2, 32'd1);
    run_op(5'd1, 5'd2, 5'd4, OP_SUB, 1'b0, 5'd0, 32'd0);
    check("t3_res", bus.result, 32'h7FFF_FFFF);
    check("t3_of", {31'd0, bus.of}, 32'd1);

    // zero flag, then SLT
    ext_load(5'd1, 32'd3);
    ext_load(5'd2, 32'd3);
    run_op(5'd1, 5'd2, 5'd10, OP_SUB, 1'b0, 5'd0, 32'd0);
    check("t4_zf", {31'd0, bus.zf}, 32'd1);
    ext_load(5'd1, 32'd2);
    ext_load(5'd2, 32'd9);
    run_op(5'd1, 5'd2, 5'd11, OP_SLT, 1'b0, 5'd0, 32'd0);
    check("t4_slt", bus.result, 32'd1);
    check("t4_zf2", {31'd0, bus.zf}, 32'd0);

    // ext_we and start together: READ sees the freshly loaded value
    run_op(5'd12, 5'd2, 5'd13, OP_ADD, 1'b1, 5'd12, 32'd100);
    check("same_cyc", bus.result, 32'd109);

    // start and ext_we while busy are ignored
    ext_load(5'd5, 32'd17);
    @(negedge clk);
    bus.start = 1'b1; bus.ra_addr = 5'd1; bus.rb_addr = 5'd2; bus.rw_addr = 5'd3; bus.op_in = OP_ADD;
    @(negedge clk);
    bus.ra_addr = 5'd5; bus.rb_addr = 5'd5; bus.rw_addr = 5'd5; bus.op_in = OP_OR;
    bus.ext_we = 1'b1; bus.ext_addr = 5'd5; bus.ext_wdata = 32'hAA;
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    check("busy_done", {31'd0, bus.done}, 32'd1);
    check("busy_res", bus.result, 32'd11);
    @(negedge clk);
    model_wr(5'd3, 32'd11);
    check("noq_busy1", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("noq_busy2", {31'd0, bus.busy}, 32'd0);
    run_op(5'd5, 5'd5, 5'd14, OP_OR, 1'b0, 5'd0, 32'd0);
    check("r5_kept", bus.result, 32'd17);

    // reset in EXEC aborts the write-back and clears everything
    @(negedge clk);
    bus.start = 1'b1; bus.ra_addr = 5'd1; bus.rb_addr = 5'd2; bus.rw_addr = 5'd6; bus.op_in = OP_ADD;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("exec_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_res", bus.result, 32'd0);
    check("abort_zf", {31'd0, bus.zf}, 32'd1);
    @(negedge clk);
    check("abort_idle", {31'd0, bus.busy}, 32'd0);
    run_op(5'd6, 5'd1, 5'd15, OP_OR, 1'b0, 5'd0, 32'd0);
    check("abort_rf", bus.result, 32'd0);

    // register zero behaviour
    ext_load(5'd0, 32'h55);
    run_op(5'd0, 5'd0, 5'd16, OP_OR, 1'b0, 5'd0, 32'd0);
`ifdef REG_ZERO_HARDWIRED_EN
    check("r0_res", bus.result, 32'd0);
    check("r0_zf", {31'd0, bus.zf}, 32'd1);
`else
    check("r0_res", bus.result, 32'h55);
    check("r0_zf", {31'd0, bus.zf}, 32'd0);
`endif

    // randomized mix, back-to-back requests, narrow address range for hazards
    for (int i = 0; i < 80; i++) begin
      logic [4:0]  ra, rb, rw, ea;
      logic [31:0] d;
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      rw = 5'($urandom_range(0, 7));
      ea = 5'($urandom_range(0, 7));
      d  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) ext_load(ea, d);
      else run_op(ra, rb, rw, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), ea, d);
    end

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
